rot_dma_ctrl: RTL and testbench

Sequencer for the rotate DMA datapath (AHB interface plus input/output byte buffers). Per tile it:
- issues one INCR read burst of BEATS words into the input buffer;
- shuffles RGB pixels from the input buffer into the output buffer, either as a straight copy or reversed (180° line rotation);
- issues one write burst to the destination.
It repeats this for NTILES tiles and then pulses done. It sits between the register block and the DMA datapath and drives every DMA control and buffer-address input.

---
 rtl/rot_pkg.sv | 29 ++
 rtl/rot_beat_cnt.sv | 68 ++++++
 rtl/rot_dma_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_rot_dma_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotate DMA controller: FSM states, AHB encodings
// and the pixel byte-address helper.
package rot_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRdReq   = 3'd1,
        StRdBurst = 3'd2,
        StShuffle = 3'd3,
        StWrReq   = 3'd4,
        StWrBurst = 3'd5,
        StNext    = 3'd6,
        StFin     = 3'd7
    } dctl_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int unsigned BYTES_PER_PIX = 3;

    // Byte address of the first (R) channel of a pixel in a buffer
    function automatic logic [7:0] pix_addr(input logic [7:0] pix);
        return 8'(BYTES_PER_PIX * pix);
    endfunction

endpackage

// File: rtl/rot_beat_cnt.sv
// AHB beat tracker: counts accepted address beats and completed data beats of
// one burst and flags the cycle in which the last data beat completes.
module rot_beat_cnt
    import rot_pkg::*;
#(
    parameter int unsigned BEATS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic [4:0] d_cnt,
    output logic       dp,
    output logic       burst_done
);

    localparam logic [4:0] BEATS_W = 5'(BEATS);
    localparam logic [4:0] LAST    = 5'(BEATS - 1);

    logic [4:0] a_q;
    logic [4:0] d_q;
    logic       dp_q;
    logic       addr_req;
    logic       addr_acc;
    logic       data_done;

    // Only NONSEQ/SEQ transfers carry an address beat
    always_comb begin
        addr_req = 1'b0;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: addr_req = 1'b1;
            HTRANS_IDLE:               addr_req = 1'b0;
            default:                   addr_req = 1'b0;
        endcase
    end

    // Address beats beyond the burst length are never counted
    assign addr_acc   = en & hready & addr_req & (a_q != BEATS_W);
    assign data_done  = en & hready & dp_q;
    assign burst_done = data_done & (d_q == LAST);

    // Beat counters and data-phase pending flag
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_q  <= 5'd0;
            d_q  <= 5'd0;
            dp_q <= 1'b0;
        end else begin
            if (addr_acc) begin
                a_q <= a_q + 5'd1;
            end
            if (data_done) begin
                d_q <= d_q + 5'd1;
            end
            if (addr_acc) begin
                dp_q <= 1'b1;
            end else if (data_done) begin
                dp_q <= 1'b0;
            end
        end
    end

    assign d_cnt = d_q;
    assign dp    = dp_q;

endmodule

// File: rtl/rot_dma_ctrl.sv
// Rotate DMA sequencer: per tile, read burst -> pixel shuffle -> write burst.
// Optional watchdog enabled by defining ROT_DCTL_TIMEOUT_EN.
module rot_dma_ctrl
    import rot_pkg::*;
#(
    parameter int unsigned BEATS  = 12,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        I_DCTL_HCLK,
    input  logic        I_DCTL_HRESET,
    input  logic        I_DCTL_START,
    input  logic [31:0] I_DCTL_SRC_BASE,
    input  logic [31:0] I_DCTL_DST_BASE,
    input  logic [15:0] I_DCTL_NTILES,
    input  logic        I_DCTL_DIR,
    input  logic [1:0]  I_DCTL_HTRANS,
    input  logic        I_DCTL_HREADY,
    output logic        O_DCTL_DMA_START,
    output logic [31:0] O_DCTL_DMA_ADDR,
    output logic [4:0]  O_DCTL_DMA_COUNT,
    output logic [2:0]  O_DCTL_DMA_SIZE,
    output logic        O_DCTL_DMA_WRITE,
    output logic [7:0]  O_DCTL_IN_ADDR0,
    output logic [7:0]  O_DCTL_IN_ADDR1,
    output logic [7:0]  O_DCTL_IN_ADDR2,
    output logic [7:0]  O_DCTL_IN_ADDR3,
    output logic [7:0]  O_DCTL_OUT_ADDRR,
    output logic [7:0]  O_DCTL_OUT_ADDRG,
    output logic [7:0]  O_DCTL_OUT_ADDRB,
    output logic [7:0]  O_DCTL_IN_ADDRR,
    output logic [7:0]  O_DCTL_IN_ADDRG,
    output logic [7:0]  O_DCTL_IN_ADDRB,
    output logic [7:0]  O_DCTL_OUT_ADDR0,
    output logic [7:0]  O_DCTL_OUT_ADDR1,
    output logic [7:0]  O_DCTL_OUT_ADDR2,
    output logic [7:0]  O_DCTL_OUT_ADDR3,
    output logic        O_DCTL_BUSY,
    output logic        O_DCTL_DONE,
    output logic        O_DCTL_ERR
);

    localparam int unsigned PIX        = BEATS * 4 / 3;
    localparam logic [31:0] TILE_BYTES = 32'(4 * BEATS);
    localparam logic [7:0]  PIX8       = 8'(PIX);
    localparam logic [7:0]  PIX_LAST   = 8'(PIX - 1);
    localparam logic [7:0]  RD_LAT8    = 8'(RD_LAT);
    localparam logic [7:0]  SH_LAST    = 8'(PIX + RD_LAT - 1);

    dctl_state_e state_q;
    dctl_state_e state_d;

    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] ntiles_q;
    logic        dir_q;
    logic [15:0] t_q;
    logic [15:0] t_next;
    logic [7:0]  sh_q;
    logic        busy_q;
    logic        done_q;

    logic        start_acc;
    logic        in_burst;
    logic        timeout;
    logic [4:0]  d_cnt;
    logic        dp;
    logic        burst_done;
    logic [7:0]  beat_byte;
    logic [15:0] wr_tile;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [7:0]  wr_pix;
    logic [7:0]  dst_pix;
    logic [7:0]  rd_base;
    logic [7:0]  wr_base;

    assign start_acc = (state_q == StIdle) & I_DCTL_START;
    assign in_burst  = (state_q == StRdBurst) || (state_q == StWrBurst);
    assign t_next    = t_q + 16'd1;
    assign beat_byte = {1'b0, d_cnt, 2'b00};

    // Reverse mode writes tiles back to front so whole lines end up rotated
    assign wr_tile = dir_q ? (ntiles_q - 16'd1 - t_q) : t_q;
    assign rd_addr = src_q + 32'(t_q) * TILE_BYTES;
    assign wr_addr = dst_q + 32'(wr_tile) * TILE_BYTES;

    // Output-buffer writes trail input-buffer reads by the read latency
    assign wr_pix  = sh_q - RD_LAT8;
    assign dst_pix = dir_q ? (PIX_LAST - wr_pix) : wr_pix;
    assign rd_base = pix_addr(sh_q);
    assign wr_base = pix_addr(dst_pix);

    rot_beat_cnt #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk        (I_DCTL_HCLK),
        .rst        (I_DCTL_HRESET),
        .clr        (!in_burst),
        .en         (in_burst),
        .htrans     (I_DCTL_HTRANS),
        .hready     (I_DCTL_HREADY),
        .d_cnt      (d_cnt),
        .dp         (dp),
        .burst_done (burst_done)
    );

`ifdef ROT_DCTL_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        err_q;

    assign timeout = in_burst & (wdog_q == 16'hFFFF);

    // Watchdog restarts on each burst entry and runs while a burst is open
    always_ff @(posedge I_DCTL_HCLK) begin
        if (I_DCTL_HRESET || !in_burst) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_q + 16'd1;
        end
    end

    // Sticky error, cleared by reset or the next accepted start
    always_ff @(posedge I_DCTL_HCLK) begin
        if (I_DCTL_HRESET) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign O_DCTL_ERR = err_q;
`else
    assign timeout    = 1'b0;
    assign O_DCTL_ERR = 1'b0;
`endif

    // State register
    always_ff @(posedge I_DCTL_HCLK) begin
        if (I_DCTL_HRESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus all DMA and buffer-address outputs
    always_comb begin
        state_d          = state_q;
        O_DCTL_DMA_START = 1'b0;
        O_DCTL_DMA_ADDR  = 32'd0;
        O_DCTL_DMA_WRITE = 1'b0;
        O_DCTL_IN_ADDR0  = 8'd0;
        O_DCTL_IN_ADDR1  = 8'd0;
        O_DCTL_IN_ADDR2  = 8'd0;
        O_DCTL_IN_ADDR3  = 8'd0;
        O_DCTL_OUT_ADDRR = 8'd0;
        O_DCTL_OUT_ADDRG = 8'd0;
        O_DCTL_OUT_ADDRB = 8'd0;
        O_DCTL_IN_ADDRR  = 8'd0;
        O_DCTL_IN_ADDRG  = 8'd0;
        O_DCTL_IN_ADDRB  = 8'd0;
        O_DCTL_OUT_ADDR0 = 8'd0;
        O_DCTL_OUT_ADDR1 = 8'd0;
        O_DCTL_OUT_ADDR2 = 8'd0;
        O_DCTL_OUT_ADDR3 = 8'd0;
        case (state_q)
            StIdle: begin
                if (I_DCTL_START) begin
                    state_d = (I_DCTL_NTILES == 16'd0) ? StFin : StRdReq;
                end
            end
            StRdReq: begin
                O_DCTL_DMA_START = 1'b1;
                O_DCTL_DMA_ADDR  = rd_addr;
                state_d          = StRdBurst;
            end
            StRdBurst: begin
                if (dp) begin
                    O_DCTL_IN_ADDR0 = beat_byte;
                    O_DCTL_IN_ADDR1 = beat_byte + 8'd1;
                    O_DCTL_IN_ADDR2 = beat_byte + 8'd2;
                    O_DCTL_IN_ADDR3 = beat_byte + 8'd3;
                end
                if (burst_done) begin
                    state_d = StShuffle;
                end
            end
            StShuffle: begin
                if (sh_q < PIX8) begin
                    O_DCTL_OUT_ADDRR = rd_base;
                    O_DCTL_OUT_ADDRG = rd_base + 8'd1;
                    O_DCTL_OUT_ADDRB = rd_base + 8'd2;
                end
                if (sh_q >= RD_LAT8) begin
                    O_DCTL_IN_ADDRR = wr_base;
                    O_DCTL_IN_ADDRG = wr_base + 8'd1;
                    O_DCTL_IN_ADDRB = wr_base + 8'd2;
                end
                if (sh_q == SH_LAST) begin
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                O_DCTL_DMA_START = 1'b1;
                O_DCTL_DMA_WRITE = 1'b1;
                O_DCTL_DMA_ADDR  = wr_addr;
                state_d          = StWrBurst;
            end
            StWrBurst: begin
                if (dp) begin
                    O_DCTL_OUT_ADDR0 = beat_byte;
                    O_DCTL_OUT_ADDR1 = beat_byte + 8'd1;
                    O_DCTL_OUT_ADDR2 = beat_byte + 8'd2;
                    O_DCTL_OUT_ADDR3 = beat_byte + 8'd3;
                end
                if (burst_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                state_d = (t_next < ntiles_q) ? StRdReq : StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (timeout) begin
            state_d = StFin;
        end
    end

    // Job configuration, captured only on an accepted start
    always_ff @(posedge I_DCTL_HCLK) begin
        if (I_DCTL_HRESET) begin
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            ntiles_q <= 16'd0;
            dir_q    <= 1'b0;
        end else if (start_acc) begin
            src_q    <= I_DCTL_SRC_BASE;
            dst_q    <= I_DCTL_DST_BASE;
            ntiles_q <= I_DCTL_NTILES;
            dir_q    <= I_DCTL_DIR;
        end
    end

    // Tile index
    always_ff @(posedge I_DCTL_HCLK) begin
        if (I_DCTL_HRESET || start_acc) begin
            t_q <= 16'd0;
        end else if (state_q == StNext) begin
            t_q <= t_next;
        end
    end

    // Shuffle cycle counter, idle at zero outside the shuffle
    always_ff @(posedge I_DCTL_HCLK) begin
        if (I_DCTL_HRESET || (state_q != StShuffle)) begin
            sh_q <= 8'd0;
        end else begin
            sh_q <= sh_q + 8'd1;
        end
    end

    // Busy/done: done pulses on the same edge that drops busy
    always_ff @(posedge I_DCTL_HCLK) begin
        if (I_DCTL_HRESET) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == StFin);
            if (start_acc) begin
                busy_q <= 1'b1;
            end else if (state_q == StFin) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign O_DCTL_BUSY      = busy_q;
    assign O_DCTL_DONE      = done_q;
    assign O_DCTL_DMA_COUNT = 5'(BEATS);
    assign O_DCTL_DMA_SIZE  = HSIZE_WORD;

endmodule

// File: tb/tb_rot_dma_ctrl.sv
// Self-checking bench for rot_dma_ctrl: table of jobs plus abort and
// (when ROT_DCTL_TIMEOUT_EN is defined) watchdog sequences.
module tb_rot_dma_ctrl;
    import rot_pkg::*;

    localparam int BEATS = 12;
    localparam int PIX   = 16;
    localparam int TILE  = 48;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] ntiles;
    logic        dir;
    logic [1:0]  htrans;
    logic        hready;
    logic        dma_start;
    logic [31:0] dma_addr;
    logic [4:0]  dma_count;
    logic [2:0]  dma_size;
    logic        dma_write;
    logic [7:0]  in0, in1, in2, in3;
    logic [7:0]  out_r, out_g, out_b;
    logic [7:0]  in_r, in_g, in_b;
    logic [7:0]  out0, out1, out2, out3;
    logic        busy;
    logic        done;
    logic        err;

    rot_dma_ctrl #(
        .BEATS  (12),
        .RD_LAT (1)
    ) dut (
        .I_DCTL_HCLK      (clk),
        .I_DCTL_HRESET    (rst),
        .I_DCTL_START     (start),
        .I_DCTL_SRC_BASE  (src),
        .I_DCTL_DST_BASE  (dst),
        .I_DCTL_NTILES    (ntiles),
        .I_DCTL_DIR       (dir),
        .I_DCTL_HTRANS    (htrans),
        .I_DCTL_HREADY    (hready),
        .O_DCTL_DMA_START (dma_start),
        .O_DCTL_DMA_ADDR  (dma_addr),
        .O_DCTL_DMA_COUNT (dma_count),
        .O_DCTL_DMA_SIZE  (dma_size),
        .O_DCTL_DMA_WRITE (dma_write),
        .O_DCTL_IN_ADDR0  (in0),
        .O_DCTL_IN_ADDR1  (in1),
        .O_DCTL_IN_ADDR2  (in2),
        .O_DCTL_IN_ADDR3  (in3),
        .O_DCTL_OUT_ADDRR (out_r),
        .O_DCTL_OUT_ADDRG (out_g),
        .O_DCTL_OUT_ADDRB (out_b),
        .O_DCTL_IN_ADDRR  (in_r),
        .O_DCTL_IN_ADDRG  (in_g),
        .O_DCTL_IN_ADDRB  (in_b),
        .O_DCTL_OUT_ADDR0 (out0),
        .O_DCTL_OUT_ADDR1 (out1),
        .O_DCTL_OUT_ADDR2 (out2),
        .O_DCTL_OUT_ADDR3 (out3),
        .O_DCTL_BUSY      (busy),
        .O_DCTL_DONE      (done),
        .O_DCTL_ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ntiles;
        logic        dir;
        logic [31:0] src;
        logic [31:0] dst;
        int          stall_at;
        logic [31:0] rd_first;
        logic [31:0] rd_last;
        logic [31:0] wr_first;
        logic [31:0] wr_last;
    } job_t;

    job_t jobs [6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [159:0] out_view();
        return {dma_start, dma_write, busy, done, err, dma_addr, in0, in1, in2, in3,
                out_r, out_g, out_b, in_r, in_g, in_b, out0, out1, out2, out3};
    endfunction

    task automatic check_reset_view(input string name);
        chk({name, "_outs"}, out_view(), '0);
        chk({name, "_count"}, dma_count, 5'd12);
        chk({name, "_size"}, dma_size, 3'b010);
    endtask

    // Zero-wait AHB model with an optional 3-cycle HREADY stall and optional reset abort
    task automatic run_burst(input bit wr, input int stall_at, input int abort_at,
                             output bit aborted);
        int a = 0;
        int d = 0;
        bit dp = 1'b0;
        int stall_left = 3;
        int guard = 0;
        logic [7:0] b;
        aborted = 1'b0;
        while (d < BEATS) begin
            guard++;
            if (guard > 60) begin
                chk("burst_budget", d, BEATS);
                htrans = HTRANS_IDLE;
                hready = 1'b1;
                return;
            end
            if (abort_at >= 0 && dp && d == abort_at) begin
                rst = 1'b1;
                htrans = HTRANS_IDLE;
                hready = 1'b1;
                tick();
                rst = 1'b0;
                settle();
                check_reset_view("abort");
                aborted = 1'b1;
                return;
            end
            hready = !(stall_at >= 0 && dp && d == stall_at && stall_left > 0);
            if (!hready) stall_left--;
            htrans = (a >= BEATS) ? HTRANS_IDLE : ((a == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            settle();
            chk("burst_ctl", {dma_start, busy}, 2'b01);
            if (dp) begin
                b = 8'(4 * d);
                if (wr) chk("wr_beat_addr", {out0, out1, out2, out3},
                            {b, b + 8'd1, b + 8'd2, b + 8'd3});
                else    chk("rd_beat_addr", {in0, in1, in2, in3},
                            {b, b + 8'd1, b + 8'd2, b + 8'd3});
            end
            if (hready) begin
                if (dp) d++;
                dp = (a < BEATS);
                if (dp) a++;
            end
            tick();
        end
        htrans = HTRANS_IDLE;
        hready = 1'b1;
    endtask

    task automatic run_job(input job_t j, input int abort_wr_at,
                           output logic [31:0] rd_first, output logic [31:0] rd_last,
                           output logic [31:0] wr_first, output logic [31:0] wr_last);
        bit ab;
        logic [31:0] exp_a;
        int q;
        logic [23:0] exp_rd;
        logic [23:0] exp_wr;
        rd_first = '0; rd_last = '0; wr_first = '0; wr_last = '0;
        start = 1'b1; src = j.src; dst = j.dst; ntiles = j.ntiles; dir = j.dir;
        htrans = HTRANS_IDLE; hready = 1'b1;
        settle();
        chk("idle_busy", busy, 1'b0);
        tick();
        // Garbage config after acceptance must not leak into the job
        start = 1'b0; src = 32'hDEAD0000; dst = 32'hBEEF0000; ntiles = 16'd7; dir = ~j.dir;
        if (j.ntiles == 16'd0) begin
            settle();
            chk("n0_cycle1", {busy, done, dma_start}, 3'b100);
            tick();
            settle();
            chk("n0_cycle2", {busy, done, dma_start}, 3'b010);
            tick();
            settle();
            chk("n0_cycle3", {busy, done}, 2'b00);
            return;
        end
        for (int t = 0; t < int'(j.ntiles); t++) begin
            settle();
            exp_a = j.src + 32'(t * TILE);
            chk("rd_req", {dma_start, dma_write, dma_count, dma_size}, {2'b10, 5'd12, 3'b010});
            chk("rd_addr", dma_addr, exp_a);
            if (t == 0) rd_first = dma_addr;
            rd_last = dma_addr;
            tick();
            run_burst(1'b0, j.stall_at, -1, ab);
            for (int c = 0; c < PIX + 1; c++) begin
                start = (c == 3);
                settle();
                exp_rd = (c < PIX) ? {8'(3 * c), 8'(3 * c + 1), 8'(3 * c + 2)} : 24'd0;
                q = j.dir ? (PIX - c) : (c - 1);
                exp_wr = (c >= 1) ? {8'(3 * q), 8'(3 * q + 1), 8'(3 * q + 2)} : 24'd0;
                chk("shuf_rd", {out_r, out_g, out_b}, exp_rd);
                chk("shuf_wr", {in_r, in_g, in_b}, exp_wr);
                tick();
            end
            start = 1'b0;
            settle();
            exp_a = j.dir ? j.dst + 32'((int'(j.ntiles) - 1 - t) * TILE)
                          : j.dst + 32'(t * TILE);
            chk("wr_req", {dma_start, dma_write}, 2'b11);
            chk("wr_addr", dma_addr, exp_a);
            if (t == 0) wr_first = dma_addr;
            wr_last = dma_addr;
            tick();
            run_burst(1'b1, j.stall_at, abort_wr_at, ab);
            if (ab) return;
            settle();
            chk("next", {dma_start, busy, done}, 3'b010);
            tick();
        end
        settle();
        chk("fin", {busy, done}, 2'b10);
        tick();
        settle();
        chk("done_pulse", {busy, done}, 2'b01);
        tick();
        settle();
        chk("done_end", {busy, done}, 2'b00);
    endtask

    initial begin
        logic [31:0] rf, rl, wf, wl;
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; ntiles = '0; dir = 1'b0;
        htrans = HTRANS_IDLE; hready = 1'b1;
        tick();
        tick();
        settle();
        check_reset_view("reset");
        rst = 1'b0;
        tick();
        settle();
        check_reset_view("post_reset");

        jobs[0] = '{16'd1, 1'b0, 32'h1000, 32'h2000, -1,
                    32'h1000, 32'h1000, 32'h2000, 32'h2000};
        jobs[1] = '{16'd3, 1'b1, 32'h0, 32'h100, -1,
                    32'h0, 32'h60, 32'h160, 32'h100};
        jobs[2] = '{16'd2, 1'b0, 32'h1000, 32'h2000, 5,
                    32'h1000, 32'h1030, 32'h2000, 32'h2030};
        jobs[3] = '{16'd2, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 11,
                    32'hFFFF_FFF0, 32'h20, 32'h10, 32'hFFFF_FFE0};
        jobs[4] = '{16'd0, 1'b0, 32'h3000, 32'h4000, -1,
                    32'h0, 32'h0, 32'h0, 32'h0};
        jobs[5] = '{16'd1, 1'b1, 32'h40, 32'h80, 0,
                    32'h40, 32'h40, 32'h80, 32'h80};

        for (int i = 0; i < 6; i++) begin
            run_job(jobs[i], -1, rf, rl, wf, wl);
            if (jobs[i].ntiles != 16'd0) begin
                chk($sformatf("job%0d_rd_first", i), rf, jobs[i].rd_first);
                chk($sformatf("job%0d_rd_last", i), rl, jobs[i].rd_last);
                chk($sformatf("job%0d_wr_first", i), wf, jobs[i].wr_first);
                chk($sformatf("job%0d_wr_last", i), wl, jobs[i].wr_last);
            end
        end

        // Reset in the middle of a write burst, then a clean job
        run_job(jobs[0], 4, rf, rl, wf, wl);
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            chk("post_abort", {busy, done, dma_start}, 3'b000);
        end
        tick();
        run_job(jobs[1], -1, rf, rl, wf, wl);
        chk("rerun_wr_first", wf, 32'h160);
        chk("rerun_wr_last", wl, 32'h100);

`ifdef ROT_DCTL_TIMEOUT_EN
        begin
            int n;
            start = 1'b1; src = 32'h0; dst = 32'h0; ntiles = 16'd1; dir = 1'b0;
            tick();
            start = 1'b0;
            tick();
            htrans = HTRANS_NONSEQ;
            hready = 1'b0;
            n = 0;
            settle();
            while (!done && n < 70000) begin
                tick();
                settle();
                n++;
            end
            chk("to_done", done, 1'b1);
            chk("to_err", err, 1'b1);
            htrans = HTRANS_IDLE;
            hready = 1'b1;
            tick();
            settle();
            chk("to_err_sticky", err, 1'b1);
            start = 1'b1; ntiles = 16'd0;
            tick();
            start = 1'b0;
            settle();
            chk("to_err_clear", err, 1'b0);
            tick();
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
